ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link; the complement of the keyboard receive path. It sends one command byte to the keyboard, for example 0xED for set-LEDs or 0xFF for reset. It inhibits the bus, issues the request-to-send, shifts the byte out LSB-first with odd parity and stop on device-generated clock edges, then checks the device acknowledge. It shares the open-drain PS2_CLK/PS2_DAT lines with the receiver, which must ignore traffic while busy is high.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low before the request (120 us).
START_TIMEOUT, 750000, max cycles from request to first device falling edge (15 ms).
XFER_TIMEOUT, 100000, max cycles from first falling edge to acknowledge (2 ms).

Ports:
CLOCK_50  input  1  system clock, 50 MHz; all logic on posedge.
resetn  input  1  asynchronous, active-low reset.
send_command  input  1  request strobe; sampled only in IDLE.
the_command  input  8  command byte; latched on accept.
PS2_CLK  inout  1  open-drain; driven 0 or Z only.
PS2_DAT  inout  1  open-drain; driven 0 or Z only.
busy  output  1  high from accept until return to IDLE.
command_was_sent  output  1  one-cycle pulse on acknowledged completion.
error_timeout  output  1  one-cycle pulse on START_TIMEOUT or XFER_TIMEOUT expiry.
error_no_ack  output  1  one-cycle pulse when the device does not acknowledge.

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy, command_was_sent, error_timeout, error_no_ack = 0; both lines Z; counters and shift register cleared. Reset mid-transfer releases both lines immediately, with no wait for a clock edge.
- Inputs: PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser. fall = previous synced CLK 1 and current synced CLK 0.
- Shift register: 9 bits {odd parity, the_command} latched on accept. Parity = ~^the_command.
- Bit counter: 0..10, counts falling edges.
- IDLE: lines Z. If send_command=1: latch the byte, set busy=1, go to INHIBIT on the next cycle. send_command while busy is ignored.
- INHIBIT: drive CLK low and count cycles. At count INHIBIT_CYCLES-1, drive DAT low (start bit), go to REQ.
- REQ: release CLK (Z); hold DAT low; reset the timeout counter.
  - If START_TIMEOUT cycles pass with no fall: go to ABORT with error_timeout.
  - On the first fall: drive DAT per bit0 (0 means drive low, 1 means Z); bitcnt=1; go to SHIFT; reset the timeout counter.
- SHIFT: on each fall, bitcnt++.
  - bitcnt 1..7 on entry: output data bit[bitcnt].
  - bitcnt=8: output parity.
  - bitcnt=9: release DAT (stop bit = 1); go to ACK.
- ACK: on the next fall, sample synced DAT.
  - DAT=0: go to RELEASE.
  - DAT=1: go to ABORT with error_no_ack.
- RELEASE: wait until synced CLK=1 and synced DAT=1, then pulse command_was_sent for one cycle and go to IDLE with busy=0 in the same cycle.
- XFER_TIMEOUT runs through SHIFT, ACK and RELEASE, counted from the first fall. On expiry: go to ABORT with error_timeout.
- ABORT: one cycle. Lines Z, the selected error pulse=1, busy=0 on exit to IDLE.
- Exactly one of the three result pulses fires per accepted command.
- A fall coincident with a timeout expiry: the timeout wins.
- Data changes only in the cycle after a detected fall, so it is stable before the device samples on the rising edge.

Test Plan:
- Device BFM clocks at 12.5 kHz and acks. send_command with the_command=0xED -> CLK low for exactly 6000 cycles, then DAT low. Bits on DAT, LSB first: 1,0,1,1,0,1,1,1, parity=1, stop=1. command_was_sent pulses once; busy falls the same cycle.
- the_command=0x00 -> parity bit=1. the_command=0x01 -> parity bit=0. Both complete.
- BFM never clocks -> error_timeout pulses 750000 cycles after REQ entry; lines Z; busy=0.
- BFM stops clocking after 4 edges -> error_timeout at 100000 cycles after the first fall; no command_was_sent.
- BFM leaves DAT high at the 11th fall -> error_no_ack pulses once; a follow-on send of 0xFF then succeeds.
- resetn asserted during SHIFT -> both lines Z asynchronously; all outputs 0; a second send_command while busy has no effect (one transfer observed).

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Host-to-device half of the PS/2 link. Sends one command byte to the
//   keyboard: inhibits the bus, issues request-to-send, shifts the byte out
//   LSB-first with odd parity and stop bit on device-generated clock edges,
//   then checks the device acknowledge.
//
// Ports
//   CLOCK_50          system clock, all logic on posedge
//   resetn            asynchronous active-low reset
//   send_command      request strobe, only looked at while idle
//   the_command[7:0]  command byte, latched when the request is accepted
//   PS2_CLK, PS2_DAT  open-drain bus lines, driven 0 or Z only
//   busy              high from accept until back in idle; the receive
//                     path must ignore the bus while this is high
//   command_was_sent  one-cycle pulse, device acknowledged the byte
//   error_timeout     one-cycle pulse, device never started or stalled
//   error_no_ack      one-cycle pulse, device left DAT high at acknowledge
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,   // CLK held low before the request
    parameter int START_TIMEOUT  = 750000, // request to first device fall
    parameter int XFER_TIMEOUT   = 100000  // first fall to acknowledge/release
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       send_command,
    input  logic [7:0] the_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timeout,
    output logic       error_no_ack
);

    localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_T = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
    localparam int TW    = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST    = TW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_RELEASE,
        S_ABORT
    } state_t;

    state_t          state;
    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            clk_prev;
    logic [8:0]      shift_reg;     // {odd parity, command byte}
    logic [3:0]      bit_cnt;       // device falling edges seen, 0..10
    logic [TW-1:0]   timer;         // inhibit length, then start/xfer timeouts
    logic            clk_drive_low;
    logic            dat_drive_low;
    logic            fall;

    // Drive enables are flops cleared by the async reset, so a reset in the
    // middle of a transfer lets go of both lines at once.
    assign PS2_CLK = clk_drive_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive_low ? 1'b0 : 1'bz;

    assign fall = clk_prev & ~clk_sync[1];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            // Synchronisers reset to the idle-high bus level so leaving
            // reset cannot look like a falling edge.
            clk_sync         <= 2'b11;
            dat_sync         <= 2'b11;
            clk_prev         <= 1'b1;
            shift_reg        <= '0;
            bit_cnt          <= '0;
            timer            <= '0;
            clk_drive_low    <= 1'b0;
            dat_drive_low    <= 1'b0;
            busy             <= 1'b0;
            command_was_sent <= 1'b0;
            error_timeout    <= 1'b0;
            error_no_ack     <= 1'b0;
        end else begin
            // NOTE: every state element here uses non-blocking assignment so
            // all flops update together from values sampled before the edge;
            // the pulse defaults below are overridden later in this block.
            clk_sync         <= {clk_sync[0], PS2_CLK};
            dat_sync         <= {dat_sync[0], PS2_DAT};
            clk_prev         <= clk_sync[1];
            command_was_sent <= 1'b0;
            error_timeout    <= 1'b0;
            error_no_ack     <= 1'b0;

            case (state)
                S_IDLE: begin
                    clk_drive_low <= 1'b0;
                    dat_drive_low <= 1'b0;
                    if (send_command) begin
                        shift_reg     <= {~^the_command, the_command};
                        busy          <= 1'b1;
                        timer         <= '0;
                        bit_cnt       <= '0;
                        clk_drive_low <= 1'b1;
                        state         <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        // Release CLK and present the start bit together.
                        clk_drive_low <= 1'b0;
                        dat_drive_low <= 1'b1;
                        timer         <= '0;
                        state         <= S_REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_REQ: begin
                    // Timeout is tested first so it wins over a coincident fall.
                    if (timer == START_LAST) begin
                        dat_drive_low <= 1'b0;
                        error_timeout <= 1'b1;
                        state         <= S_ABORT;
                    end else if (fall) begin
                        dat_drive_low <= ~shift_reg[0];
                        bit_cnt       <= 4'd1;
                        timer         <= '0;
                        state         <= S_SHIFT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SHIFT, S_ACK, S_RELEASE: begin
                    if (timer == XFER_LAST) begin
                        dat_drive_low <= 1'b0;
                        error_timeout <= 1'b1;
                        state         <= S_ABORT;
                    end else begin
                        timer <= timer + 1'b1;
                        case (state)
                            S_SHIFT: begin
                                if (fall) begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    if (bit_cnt == 4'd9) begin
                                        // Stop bit is a released line.
                                        dat_drive_low <= 1'b0;
                                        state         <= S_ACK;
                                    end else begin
                                        // Indices 1..7 are data, 8 is parity.
                                        dat_drive_low <= ~shift_reg[bit_cnt];
                                    end
                                end
                            end
                            S_ACK: begin
                                if (fall) begin
                                    if (!dat_sync[1]) begin
                                        state <= S_RELEASE;
                                    end else begin
                                        error_no_ack <= 1'b1;
                                        state        <= S_ABORT;
                                    end
                                end
                            end
                            default: begin
                                // Wait for the device to let go of both lines.
                                if (clk_sync[1] && dat_sync[1]) begin
                                    command_was_sent <= 1'b1;
                                    busy             <= 1'b0;
                                    state            <= S_IDLE;
                                end
                            end
                        endcase
                    end
                end

                S_ABORT: begin
                    clk_drive_low <= 1'b0;
                    dat_drive_low <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    clk_drive_low <= 1'b0;
                    dat_drive_low <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Testbench for ps2_host_transmitter. A device model clocks the bus and
// captures the frame; expected results go into a scoreboard queue and a
// monitor compares them whenever the DUT raises a result pulse.
module tb_ps2_host_transmitter;

    localparam int INH  = 60;
    localparam int STO  = 2000;
    localparam int XTO  = 1500;
    localparam int HALF = 20;   // device clock half period in system cycles

    typedef enum int { R_SENT = 0, R_TIMEOUT = 1, R_NOACK = 2 } res_t;
    typedef struct {
        res_t       kind;
        logic [9:0] frame;
        bit         chk_frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send_command = 1'b0;
    logic [7:0] the_command = 8'h00;
    logic       busy, command_was_sent, error_timeout, error_no_ack;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .XFER_TIMEOUT  (XTO)
    ) dut (
        .CLOCK_50        (clk),
        .resetn          (resetn),
        .send_command    (send_command),
        .the_command     (the_command),
        .PS2_CLK         (ps2_clk),
        .PS2_DAT         (ps2_dat),
        .busy            (busy),
        .command_was_sent(command_was_sent),
        .error_timeout   (error_timeout),
        .error_no_ack    (error_no_ack)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    exp_t       sb[$];
    logic [9:0] cap_frame;
    longint     t_err, t_req, t_first_fall;
    int         pulse_count = 0;
    int         inh_len;
    bit         req_dat_low;
    int         rise_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as the device should see it: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] c);
        logic [9:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((int'(c) / (1 << i)) % 2) == 1;
            ones += (int'(c) / (1 << i)) % 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    // Monitor: pops one expectation per result pulse.
    always @(negedge clk) begin
        if (resetn && (command_was_sent || error_timeout || error_no_ack)) begin
            res_t got;
            exp_t e;
            int   n;
            n = int'(command_was_sent) + int'(error_timeout) + int'(error_no_ack);
            check("one_result_pulse", n, 1);
            got = command_was_sent ? R_SENT : (error_timeout ? R_TIMEOUT : R_NOACK);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got kind %0d expected none", got);
            end else begin
                e = sb.pop_front();
                check("result_kind", got, e.kind);
                if (got == R_SENT) begin
                    check("busy_low_with_done", busy, 1'b0);
                    if (e.chk_frame) check("frame", cap_frame, e.frame);
                end
            end
            t_err = cyc;
            pulse_count++;
        end
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        the_command  = c;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
    endtask

    // Device model: waits for the request, then generates n_edges clock pulses,
    // sampling DAT on each rising edge; acknowledges at the 11th if asked.
    task automatic bfm(input int n_edges, input bit do_ack, output bit got_req);
        int n = 0;
        got_req   = 1'b0;
        inh_len   = 0;
        cap_frame = '0;
        rise_cnt  = 0;
        while (ps2_clk !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (ps2_clk !== 1'b0) return;
        while (ps2_clk === 1'b0 && inh_len < 5000) begin
            inh_len++;
            @(negedge clk);
        end
        req_dat_low = (ps2_dat === 1'b0);
        t_req       = cyc;
        got_req     = 1'b1;
        repeat (50) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11) begin
                dev_dat_low = do_ack;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (i == 1) t_first_fall = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            rise_cnt    = i;
            if (i <= 10) cap_frame[i-1] = ps2_dat;
            repeat (HALF) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_pulse(input int prev, input string name);
        int n = 0;
        while (pulse_count == prev && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pulse_count - prev), 1);
    endtask

    task automatic good_xfer(input logic [7:0] c);
        bit gr;
        exp_t e;
        e.kind = R_SENT; e.frame = ref_frame(c); e.chk_frame = 1'b1;
        sb.push_back(e);
        send(c);
        bfm(11, 1'b1, gr);
        check("request_seen", gr, 1'b1);
        check("inhibit_len", inh_len, INH);
        check("start_bit_low", req_dat_low, 1'b1);
        wait_idle("idle_after_sent");
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   gr;
        exp_t e;
        int   lows;
        int   prev;
        bit   win;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", command_was_sent, 1'b0);
        check("rst_timeout", error_timeout, 1'b0);
        check("rst_noack", error_no_ack, 1'b0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_clk_z", ps2_clk, 1'b1);
        check("idle_dat_z", ps2_dat, 1'b1);

        // Directed bytes and parity corners.
        good_xfer(8'hED);
        good_xfer(8'h00);
        good_xfer(8'h01);
        for (int k = 0; k < 5; k++) good_xfer(8'($urandom_range(0, 255)));

        // Device never clocks: start timeout measured from request entry.
        e.kind = R_TIMEOUT; e.frame = '0; e.chk_frame = 1'b0;
        sb.push_back(e);
        prev = pulse_count;
        send(8'hA5);
        bfm(0, 1'b0, gr);
        check("req_before_start_to", gr, 1'b1);
        wait_pulse(prev, "start_timeout_pulse");
        check("start_timeout_cycles", 32'(t_err - t_req), STO);
        wait_idle("idle_after_start_to");
        check("start_to_clk_z", ps2_clk, 1'b1);
        check("start_to_dat_z", ps2_dat, 1'b1);

        // Device stalls after 4 edges: transfer timeout from first fall.
        sb.push_back(e);
        prev = pulse_count;
        send(8'h3C);
        bfm(4, 1'b0, gr);
        wait_pulse(prev, "xfer_timeout_pulse");
        win = (t_err - t_first_fall >= XTO) && (t_err - t_first_fall <= XTO + 5);
        check("xfer_timeout_window", win, 1'b1);
        wait_idle("idle_after_xfer_to");

        // No acknowledge, then a normal 0xFF.
        e.kind = R_NOACK;
        sb.push_back(e);
        prev = pulse_count;
        send(8'h96);
        bfm(11, 1'b0, gr);
        wait_pulse(prev, "noack_pulse");
        wait_idle("idle_after_noack");
        good_xfer(8'hFF);

        // Second strobe while busy is ignored: one transfer only.
        e.kind = R_SENT; e.frame = ref_frame(8'h5A); e.chk_frame = 1'b1;
        sb.push_back(e);
        send(8'h5A);
        fork
            bfm(11, 1'b1, gr);
            begin
                repeat (10) @(negedge clk);
                the_command  = 8'h33;
                send_command = 1'b1;
                @(negedge clk);
                send_command = 1'b0;
            end
        join
        wait_idle("idle_after_double");
        lows = 0;
        repeat (3 * INH) begin
            @(negedge clk);
            if (ps2_clk === 1'b0) lows++;
        end
        check("no_second_transfer", lows, 0);

        // Asynchronous reset in the middle of the shift phase.
        send(8'h00);
        fork
            bfm(6, 1'b1, gr);
            begin
                int n = 0;
                while (rise_cnt < 3 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(negedge clk);
                #3 resetn = 1'b0;
                #1;
                check("rst_mid_dat_z", ps2_dat, 1'b1);
                check("rst_mid_clk_z", ps2_clk, 1'b1);
                check("rst_mid_busy", busy, 1'b0);
                check("rst_mid_pulses", {command_was_sent, error_timeout, error_no_ack}, 3'b000);
                repeat (3) @(negedge clk);
                resetn = 1'b1;
            end
        join
        repeat (3 * INH) @(negedge clk);
        check("busy_after_reset", busy, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
